// File: rtl/sym_dn_lut_pkg.sv
// Shared types and default sizes for the dn symbol-LUT reload path.
// Latency: none (declarations only).
// Backpressure: n/a.
package sym_dn_lut_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DEPTH_DEF  = 128;
    localparam int PLANES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        VERIFY
    } state_t;

endpackage

// File: rtl/sym_dn_lut_port_arb.sv
// Read/write-port arbiter: decoder reads win, stream writes take the idle slots.
// Latency: purely combinational.
// Backpressure: s_ready drops whenever the decoder holds the port or no load is running.
module sym_dn_lut_port_arb (
    input  logic in_load,
    input  logic s_valid,
    input  logic rd1_req,
    output logic rd1_gnt,
    output logic s_ready,
    output logic lut_we
);

    always_comb begin
        rd1_gnt = rd1_req;
        s_ready = in_load & ~rd1_req;
        lut_we  = s_ready & s_valid;
    end

    // The LUT data output is undriven during a write, so a granted read must never overlap one.
    always_comb begin
        assert (!(lut_we && rd1_gnt));
    end

endmodule

// File: rtl/sym_dn_lut_load_ctrl.sv
// Reload sequencer for the PLANES x DEPTH dn symbol LUTs; optional readback via SYM_DN_LUT_LOAD_READBACK_EN.
// Latency: 1 + DEPTH + 1 cycles start-to-done unstalled (plus DEPTH + 1 with readback verify).
// Backpressure: s_ready = LOAD & !rd1_req; decoder reads are never blocked.
module sym_dn_lut_load_ctrl
    import sym_dn_lut_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PLANES = PLANES_DEF
) (
    input  logic              write_clk,
    input  logic              rst,
    input  logic              load_start,
    output logic              load_busy,
    output logic              load_done,
    input  logic [PLANES-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              rd1_req,
    output logic              rd1_gnt,
    output logic              lut_we,
    output logic [ADDR_W-1:0] lut_waddr,
    output logic [PLANES-1:0] lut_wdata,
`ifdef SYM_DN_LUT_LOAD_READBACK_EN
    output logic [ADDR_W-1:0] rb_addr,
    input  logic [PLANES-1:0] rb_data,
`endif
    output logic              load_err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              start_acc;

    sym_dn_lut_port_arb u_arb (
        .in_load (state_q == LOAD),
        .s_valid (s_valid),
        .rd1_req (rd1_req),
        .rd1_gnt (rd1_gnt),
        .s_ready (s_ready),
        .lut_we  (lut_we)
    );

    assign start_acc = (state_q == IDLE) && load_start;
    assign lut_waddr = addr_q;
    assign lut_wdata = lut_we ? s_data : '0;

`ifdef SYM_DN_LUT_LOAD_READBACK_EN
    logic [ADDR_W-1:0] vaddr_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic [PLANES-1:0] rb_q;
    logic              cmp_vld_q;
    logic              err_q;
    logic [PLANES-1:0] shadow [DEPTH];
`endif

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (load_start) state_nxt = LOAD;
            LOAD: begin
                if (lut_we && (addr_q == LAST)) begin
`ifdef SYM_DN_LUT_LOAD_READBACK_EN
                    state_nxt = VERIFY;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef SYM_DN_LUT_LOAD_READBACK_EN
            VERIFY: if (vaddr_q == LAST) state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (start_acc) begin
                addr_q <= '0;
            end else if (lut_we) begin
                addr_q <= addr_q + 1'b1;
            end
`ifdef SYM_DN_LUT_LOAD_READBACK_EN
            // DONE is the drain cycle for the last compare; the pulse lands one cycle later.
            load_busy <= (state_nxt != IDLE);
            load_done <= (state_q == DONE);
`else
            load_busy <= (state_nxt == LOAD);
            load_done <= (state_nxt == DONE);
`endif
        end
    end

`ifdef SYM_DN_LUT_LOAD_READBACK_EN
    assign rb_addr  = vaddr_q;
    assign load_err = err_q;

    always_ff @(posedge write_clk) begin
        if (lut_we) begin
            shadow[addr_q] <= s_data;
        end
    end

    // DPO data is registered before the compare, so each check trails its address by a cycle.
    always_ff @(posedge write_clk) begin
        if (rst) begin
            vaddr_q    <= '0;
            cmp_addr_q <= '0;
            rb_q       <= '0;
            cmp_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == VERIFY) begin
                vaddr_q <= vaddr_q + 1'b1;
            end else begin
                vaddr_q <= '0;
            end
            cmp_vld_q  <= (state_q == VERIFY);
            cmp_addr_q <= vaddr_q;
            rb_q       <= rb_data;
            if (start_acc) begin
                err_q <= 1'b0;
            end else if (cmp_vld_q && (rb_q != shadow[cmp_addr_q])) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_sym_dn_lut_load_ctrl.sv
// Self-checking bench for sym_dn_lut_load_ctrl: arbitration vector table plus scoreboarded load sequences.
// Latency and readback expectations switch with SYM_DN_LUT_LOAD_READBACK_EN.
module tb_sym_dn_lut_load_ctrl;

    localparam int AW = 7;
    localparam int D  = 128;
    localparam int P  = 4;
`ifdef SYM_DN_LUT_LOAD_READBACK_EN
    localparam int EXTRA = D + 1;
`else
    localparam int EXTRA = 0;
`endif

    logic          write_clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          load_busy, load_done;
    logic [P-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          rd1_req = 1'b0;
    logic          rd1_gnt;
    logic          lut_we;
    logic [AW-1:0] lut_waddr;
    logic [P-1:0]  lut_wdata;
    logic          load_err;
    logic          fault_en = 1'b0;

    logic [P-1:0]  lut_mem [D];

`ifdef SYM_DN_LUT_LOAD_READBACK_EN
    logic [AW-1:0] rb_addr;
    logic [P-1:0]  rb_data;
    assign rb_data = lut_mem[rb_addr] ^ ((fault_en && rb_addr == 7'd33) ? 4'b0100 : 4'b0000);
`endif

    sym_dn_lut_load_ctrl dut (
        .write_clk  (write_clk),
        .rst        (rst),
        .load_start (load_start),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .rd1_req    (rd1_req),
        .rd1_gnt    (rd1_gnt),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
`ifdef SYM_DN_LUT_LOAD_READBACK_EN
        .rb_addr    (rb_addr),
        .rb_data    (rb_data),
`endif
        .load_err   (load_err)
    );

    always #5 write_clk = ~write_clk;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always @(posedge write_clk) cyc <= cyc + 1;

    always @(posedge write_clk) begin
        if (lut_we) lut_mem[lut_waddr] <= lut_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [P-1:0]  d;
    } wr_t;
    wr_t exp_q[$];

    // Scoreboard consumer: every observed write must match the oldest accepted word.
    always @(negedge write_clk) begin
        if (lut_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(exp_q.size() != 0), 32'd1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("sb_waddr", 32'(lut_waddr), 32'(e.a));
                chk("sb_wdata", 32'(lut_wdata), 32'(e.d));
            end
        end
        if (lut_we && rd1_gnt) chk("we_gnt_exclusive", 32'(lut_we & rd1_gnt), 32'd0);
        if (load_done) done_cnt++;
    end

    task automatic step();
        @(posedge write_clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  32'(load_busy), 0);
        chk({tag, "_done"},  32'(load_done), 0);
        chk({tag, "_ready"}, 32'(s_ready),   0);
        chk({tag, "_we"},    32'(lut_we),    0);
        chk({tag, "_waddr"}, 32'(lut_waddr), 0);
        chk({tag, "_wdata"}, 32'(lut_wdata), 0);
        chk({tag, "_err"},   32'(load_err),  0);
    endtask

    // mode 0 plain, 1 rd1 stall k=10..19, 2 s_valid on odd cycles, 3 repeat start at k=50, 4 reset at addr 64
    task automatic run_load(input int mode, output int lat, output int words, output logic err_at_done);
        int  k;
        int  idx;
        int  start_cyc;
        bit  done_seen;
        bit  stall;
        lat = -1;
        idx = 0;
        done_seen = 0;
        err_at_done = 1'b0;
        load_start = 1'b1;
        s_valid = 1'b0;
        rd1_req = 1'b0;
        start_cyc = cyc;
        step();
        load_start = 1'b0;
        k = 1;
        while (k < 700 && !done_seen) begin
            stall = (mode == 1) && (k >= 10) && (k <= 19);
            rd1_req = stall;
            s_valid = (mode == 2) ? (k % 2 == 1) : 1'b1;
            load_start = (mode == 3) && (k == 50);
            s_data = P'(idx);
            if (mode == 4 && idx == 64) begin
                rst = 1'b1;
                s_valid = 1'b0;
                step();
                rst = 1'b0;
                #3;
                chk_reset("rst_mid");
                words = idx;
                return;
            end
            #3;
            if (stall) begin
                chk("stall_s_ready", 32'(s_ready), 0);
                chk("stall_lut_we",  32'(lut_we),  0);
                chk("stall_rd1_gnt", 32'(rd1_gnt), 1);
            end
            if (s_valid && s_ready) begin
                exp_q.push_back('{a: AW'(idx), d: P'(idx)});
                idx++;
            end
            if (load_done) begin
                done_seen = 1;
                lat = cyc - start_cyc + 1;
                err_at_done = load_err;
            end
            step();
            k++;
        end
        s_valid = 1'b0;
        rd1_req = 1'b0;
        load_start = 1'b0;
        chk("load_done_seen", 32'(done_seen), 1);
        words = idx;
    endtask

    task automatic chk_contents(input string tag);
        for (int p = 0; p < P; p++) begin
            int bad = 0;
            for (int a = 0; a < D; a++) begin
                logic [6:0] av;
                av = 7'(a);
                if (lut_mem[a][p] !== av[p]) bad++;
            end
            chk({tag, "_plane_mism"}, 32'(bad), 0);
        end
    endtask

    typedef struct {
        bit   in_load;
        logic rd1_req;
        logic s_valid;
        logic exp_gnt;
        logic exp_rdy;
        logic exp_we;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   lat, words, d0;
        logic e;

        tbl[0] = '{0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 1, 0, 0};
        tbl[2] = '{0, 0, 1, 0, 0, 0};
        tbl[3] = '{0, 1, 1, 1, 0, 0};
        tbl[4] = '{1, 0, 0, 0, 1, 0};
        tbl[5] = '{1, 1, 0, 1, 0, 0};
        tbl[6] = '{1, 0, 1, 0, 1, 1};
        tbl[7] = '{1, 1, 1, 1, 0, 0};

        rst = 1'b1;
        step();
        step();
        #2;
        chk_reset("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                load_start = 1'b1;
                step();
                load_start = 1'b0;
                #2;
                chk("tbl_busy_in_load", 32'(load_busy), 1);
                step();
            end
            rd1_req = tbl[i].rd1_req;
            s_valid = tbl[i].s_valid;
            s_data  = 4'hA;
            #1;
            chk($sformatf("tbl%0d_gnt", i), 32'(rd1_gnt), 32'(tbl[i].exp_gnt));
            chk($sformatf("tbl%0d_rdy", i), 32'(s_ready), 32'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_we", i),  32'(lut_we),  32'(tbl[i].exp_we));
            if (tbl[i].exp_we) chk($sformatf("tbl%0d_wdata", i), 32'(lut_wdata), 32'hA);
            rd1_req = 1'b0;
            s_valid = 1'b0;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        run_load(0, lat, words, e);
        chk("plain_latency", 32'(lat), 32'(130 + EXTRA));
        chk("plain_words", 32'(words), D);
        chk("plain_err", 32'(e), 0);
        chk_contents("plain");

        run_load(1, lat, words, e);
        chk("stall_latency", 32'(lat), 32'(140 + EXTRA));
        chk("stall_words", 32'(words), D);

        run_load(2, lat, words, e);
        chk("toggle_latency", 32'(lat), 32'(257 + EXTRA));
        chk("toggle_words", 32'(words), D);
        chk_contents("toggle");

        d0 = done_cnt;
        run_load(3, lat, words, e);
        for (int i = 0; i < 5; i++) step();
        chk("restart_latency", 32'(lat), 32'(130 + EXTRA));
        chk("restart_done_count", 32'(done_cnt - d0), 1);
        chk("restart_busy_after", 32'(load_busy), 0);

        d0 = done_cnt;
        run_load(4, lat, words, e);
        chk("rst_words", 32'(words), 64);
        step();
        chk("rst_no_done", 32'(done_cnt - d0), 0);
        chk("rst_sb_empty", 32'(exp_q.size()), 0);

        run_load(0, lat, words, e);
        chk("reload_latency", 32'(lat), 32'(130 + EXTRA));
        chk_contents("reload");

`ifdef SYM_DN_LUT_LOAD_READBACK_EN
        fault_en = 1'b1;
        run_load(0, lat, words, e);
        chk("fault_latency", 32'(lat), 32'd259);
        chk("fault_err", 32'(e), 1);
        step();
        chk("fault_err_sticky", 32'(load_err), 1);
        fault_en = 1'b0;
        run_load(0, lat, words, e);
        chk("clean_err", 32'(e), 0);
`endif

        step();
        chk("final_sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
